// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, bubble insertion and flush squash; optional STALL_COUNTER_EN adds saturating stall/flush counters
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [3:0]      id_funct4,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [1:0]      id_ALUOp,
    input  logic            id_Branch,
    input  logic            id_MemRead,
    input  logic            id_MemtoReg,
    input  logic            id_MemWrite,
    input  logic            id_ALUSrc,
    input  logic            id_RegWrite,
    input  logic            flush,
    input  logic            hold,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_funct4,
    output logic [1:0]      ex_ALUOp,
    output logic            ex_Branch,
    output logic            ex_MemRead,
    output logic            ex_MemtoReg,
    output logic            ex_MemWrite,
    output logic            ex_ALUSrc,
    output logic            ex_RegWrite
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
`endif
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct4;
        logic [1:0]      alu_op;
        logic            branch;
        logic            mem_read;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
    } ex_t;

    ex_t  ex_q, ex_d, id_rec;
    logic use_rs1, use_rs2, load_use, stall;

    // hazard detection: which sources the decode instruction reads, and whether a load in EX targets one
    always_comb begin
        use_rs1  = id_opcode inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};
        use_rs2  = id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
        load_use = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rd != 5'd0) &
                   ((use_rs1 & (ex_q.rd == id_rs1)) | (use_rs2 & (ex_q.rd == id_rs2)));
        stall    = load_use & ~flush;
        pc_write    = ~stall & ~hold;
        if_id_write = ~stall & ~hold;
    end

    // next ID/EX contents: flush bubble beats hold, hold beats the load-use bubble
    always_comb begin
        id_rec = '{valid: id_valid, pc: id_pc, rdata1: id_rdata1, rdata2: id_rdata2, imm: id_imm,
                   rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct4: id_funct4, alu_op: id_ALUOp,
                   branch: id_Branch, mem_read: id_MemRead, mem_to_reg: id_MemtoReg & id_RegWrite,
                   mem_write: id_MemWrite, alu_src: id_ALUSrc, reg_write: id_RegWrite};
        ex_d = (flush || (!hold && load_use)) ? '0 : hold ? ex_q : id_rec;
    end

    // pipeline register with synchronous bubble on reset
    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rdata1   = ex_q.rdata1;
    assign ex_rdata2   = ex_q.rdata2;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct4   = ex_q.funct4;
    assign ex_ALUOp    = ex_q.alu_op;
    assign ex_Branch   = ex_q.branch;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_MemtoReg = ex_q.mem_to_reg;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_RegWrite = ex_q.reg_write;

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

    // saturating event counters
    always_comb begin
        stall_count_d = (stall & ~hold & (stall_count_q != '1)) ? stall_count_q + 32'd1 : stall_count_q;
        flush_count_d = (flush & (flush_count_q != '1)) ? flush_count_q + 32'd1 : flush_count_q;
    end

    // counter registers cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// tb_id_ex_stage: randomized scoreboard bench for id_ex_stage against a spec-level reference model
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [63:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  f4;
        logic [1:0]  aluop;
        logic        br, mr, m2r, mw, src, rw;
    } rec_t;

    typedef struct { bit chk; bit pw; } pc_exp_t;
    typedef struct { bit chk; rec_t ex; int unsigned sc; int unsigned fc; } ex_exp_t;

    logic clk = 0, reset = 1, flush = 0, hold = 0;
    rec_t cur = '0;
    logic id_valid, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [6:0]  id_opcode = 7'b0;
    logic [3:0]  id_funct4;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [1:0]  id_ALUOp;
    logic pc_write, if_id_write, ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct4;
    logic [1:0]  ex_ALUOp;
    rec_t act;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_count, flush_count;
`endif

    assign {id_valid, id_pc, id_rdata1, id_rdata2, id_imm, id_rs1, id_rs2, id_rd, id_funct4, id_ALUOp,
            id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite} = cur;
    assign act = {ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4, ex_ALUOp,
                  ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite};

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct4(id_funct4),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_pc(id_pc), .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ALUOp(id_ALUOp), .id_Branch(id_Branch),
        .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
        .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite), .flush(flush), .hold(hold),
        .pc_write(pc_write), .if_id_write(if_id_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct4(ex_funct4), .ex_ALUOp(ex_ALUOp),
        .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite)
`ifdef STALL_COUNTER_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    int total = 0, bad = 0;
    pc_exp_t pcq[$];
    ex_exp_t exq[$];
    rec_t m = '0;
    bit known = 0;
    int unsigned sc = 0, fc = 0;
    logic [6:0] ops [7] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110111, 7'b1101111};

    function automatic bit reads1(logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011 || op == 7'b0010011;
    endfunction

    function automatic bit reads2(logic [6:0] op);
        return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
    endfunction

    function automatic rec_t mk(logic [4:0] a, b, d, logic [1:0] aop, logic br, mr, m2r, mw, src, rw);
        rec_t r;
        r = '{v: 1'b1, pc: {$urandom, $urandom}, r1: {$urandom, $urandom}, r2: {$urandom, $urandom},
              imm: {$urandom, $urandom}, rs1: a, rs2: b, rd: d, f4: 4'($urandom), aluop: aop,
              br: br, mr: mr, m2r: m2r, mw: mw, src: src, rw: rw};
        return r;
    endfunction

    function automatic rec_t rnd();
        rec_t r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        r.v = $urandom_range(0, 4) != 0;
        r.rs1 = 5'($urandom_range(0, 3));
        r.rs2 = 5'($urandom_range(0, 3));
        r.rd = 5'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic step(input rec_t r, input logic [6:0] op, input bit fl, input bit hd, input bit rs);
        bit lu, kn;
        rec_t nx, ld;
        @(negedge clk);
        cur = r; id_opcode = op; flush = fl; hold = hd; reset = rs;
        #1;
        lu = m.v && m.mr && r.v && m.rd != 0 && ((reads1(op) && m.rd == r.rs1) || (reads2(op) && m.rd == r.rs2));
        pcq.push_back('{chk: known, pw: !(lu && !fl) && !hd});
        ld = r;
        ld.m2r = r.m2r && r.rw;
        nx = (rs || fl || (!hd && lu)) ? '0 : hd ? m : ld;
        kn = rs || known;
        if (rs) begin sc = 0; fc = 0; end
        else begin
            if (lu && !fl && !hd && sc != 32'hFFFF_FFFF) sc++;
            if (fl && fc != 32'hFFFF_FFFF) fc++;
        end
        exq.push_back('{chk: kn, ex: nx, sc: sc, fc: fc});
        m = nx;
        known = kn;
    endtask

    initial begin : monitor
        pc_exp_t p;
        ex_exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (pcq.size() > 0) begin
                p = pcq.pop_front();
                if (p.chk) begin
                    total++;
                    if (pc_write !== p.pw || if_id_write !== p.pw) begin
                        bad++;
                        $display("FAIL stall_ctl t=%0t pc_write=%b if_id_write=%b want=%b", $time, pc_write, if_id_write, p.pw);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                if (e.chk) begin
                    total++;
                    if (act !== e.ex) begin
                        bad++;
                        $display("FAIL ex_regs t=%0t got=%h want=%h", $time, act, e.ex);
                    end
`ifdef STALL_COUNTER_EN
                    total++;
                    if (stall_count !== e.sc || flush_count !== e.fc) begin
                        bad++;
                        $display("FAIL counters t=%0t stall=%0d flush=%0d want stall=%0d flush=%0d", $time, stall_count, flush_count, e.sc, e.fc);
                    end
`endif
                end
            end
        end
    end

    initial begin : driver
        rec_t add3, ld5, add6, ld0, use0, addi6;
        int guard;
        add3  = mk(5'd1, 5'd2, 5'd3, 2'b10, 0, 0, 0, 0, 0, 1);
        ld5   = mk(5'd1, 5'd9, 5'd5, 2'b00, 0, 1, 1, 0, 1, 1);
        add6  = mk(5'd5, 5'd1, 5'd6, 2'b10, 0, 0, 0, 0, 0, 1);
        ld0   = mk(5'd1, 5'd9, 5'd0, 2'b00, 0, 1, 1, 0, 1, 1);
        use0  = mk(5'd0, 5'd0, 5'd6, 2'b10, 0, 0, 0, 0, 0, 1);
        addi6 = mk(5'd7, 5'd5, 5'd6, 2'b10, 0, 0, 1, 0, 1, 1);
        repeat (2) step(rnd(), ops[$urandom_range(0, 6)], 0, 0, 1);
        step(add3, 7'b0110011, 0, 0, 0);
        step(ld5, 7'b0000011, 0, 0, 0);
        step(add6, 7'b0110011, 0, 0, 0);
        step(add6, 7'b0110011, 0, 0, 0);
        step(ld0, 7'b0000011, 0, 0, 0);
        step(use0, 7'b0110011, 0, 0, 0);
        step(ld5, 7'b0000011, 0, 0, 0);
        step(addi6, 7'b0010011, 0, 0, 0);
        step(ld5, 7'b0000011, 0, 0, 0);
        step(add6, 7'b0110011, 1, 0, 0);
        step(ld5, 7'b0000011, 0, 0, 0);
        step(add6, 7'b0110011, 0, 0, 1);
        step(add6, 7'b0110011, 0, 0, 0);
        step(add3, 7'b0110011, 0, 0, 0);
        repeat (3) step(rnd(), ops[$urandom_range(0, 6)], 0, 1, 0);
        step(add3, 7'b0110011, 0, 0, 0);
        step(ld5, 7'b0000011, 1, 1, 0);
        for (int i = 0; i < 3000; i++)
            step(rnd(), ops[$urandom_range(0, 6)], $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        guard = 0;
        while ((pcq.size() > 0 || exq.size() > 0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (pcq.size() > 0 || exq.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", pcq.size() + exq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
